// File: rtl/ahb_apb_bridge.sv
// Single-transfer AHB-to-APB bridge: IDLE/SETUP/ACCESS/DONE/HOLD sequencer with a 4-slave decode.
// Optional APB_TIMEOUT_EN adds a 16-cycle ACCESS timeout that completes with Htimeout and all-ones read data.
module ahb_apb_bridge (
  input  logic        HCLK,
  input  logic        Hrst,
  input  logic        Hen,
  input  logic        Hwrite,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hready,
  output logic [31:0] Hrdata,
  output logic        Htimeout,
  output logic [3:0]  PSEL,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t r_state;

`ifdef APB_TIMEOUT_EN
  logic [3:0] r_tcnt;
  logic       r_tflag;
`endif

  function automatic logic is_mapped(input logic [31:0] addr);
    return (addr[31:14] == 18'd0);
  endfunction

  function automatic logic [3:0] sel_decode(input logic [31:0] addr);
    logic [3:0] sel;
    case (addr[13:12])
      2'd0:    sel = 4'b0001;
      2'd1:    sel = 4'b0010;
      2'd2:    sel = 4'b0100;
      2'd3:    sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Transfer sequencer; Hready/Htimeout are registered from DONE, so they trail the state by one cycle.
  always_ff @(posedge HCLK or negedge Hrst) begin
    if (!Hrst) begin
      r_state  <= ST_IDLE;
      Hready   <= 1'b0;
      Htimeout <= 1'b0;
      Hrdata   <= 32'd0;
      PSEL     <= 4'b0000;
      PENABLE  <= 1'b0;
      PADDR    <= 32'd0;
      PWRITE   <= 1'b0;
      PWDATA   <= 32'd0;
`ifdef APB_TIMEOUT_EN
      r_tcnt   <= 4'd0;
      r_tflag  <= 1'b0;
`endif
    end else begin
      Hready   <= 1'b0;
      Htimeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Hen) begin
            PADDR  <= Haddr;
            PWRITE <= Hwrite;
            PWDATA <= Hwdata;
`ifdef APB_TIMEOUT_EN
            r_tflag <= 1'b0;
`endif
            if (is_mapped(Haddr)) begin
              PSEL    <= sel_decode(Haddr);
              r_state <= ST_SETUP;
            end else begin
              Hrdata  <= 32'd0;
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          r_tcnt  <= 4'd0;
`endif
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            if (!PWRITE) begin
              Hrdata <= PRDATA;
            end else begin
              Hrdata <= Hrdata;
            end
            PSEL    <= 4'b0000;
            PENABLE <= 1'b0;
            r_state <= ST_DONE;
`ifdef APB_TIMEOUT_EN
          end else if (r_tcnt == 4'd15) begin
            // 16th stalled ACCESS cycle: abandon the slave and report all-ones data
            Hrdata  <= 32'hFFFF_FFFF;
            r_tflag <= 1'b1;
            PSEL    <= 4'b0000;
            PENABLE <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_tcnt  <= r_tcnt + 4'd1;
            r_state <= ST_ACCESS;
`else
          end else begin
            r_state <= ST_ACCESS;
`endif
          end
        end
        ST_DONE: begin
          Hready   <= 1'b1;
`ifdef APB_TIMEOUT_EN
          Htimeout <= r_tflag;
`else
          Htimeout <= 1'b0;
`endif
          r_state  <= ST_HOLD;
        end
        ST_HOLD: begin
          // wait for the master to drop Hen so a held request is not re-issued
          if (!Hen) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          PSEL    <= 4'b0000;
          PENABLE <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 SHALL have port HCLK, input, 1 bit: clock; all logic on rising edge.
REQ-002 SHALL have port Hrst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port Hen, input, 1 bit: transfer enable from AHB master; level, held high until the master sees Hready.
REQ-004 SHALL have port Hwrite, input, 1 bit: 1 write, 0 read.
REQ-005 SHALL have port Haddr, input, 32 bits: transfer address.
REQ-006 SHALL have port Hwdata, input, 32 bits: write data.
REQ-007 SHALL have port Hready, output, 1 bit: one-cycle transfer-complete pulse to the master.
REQ-008 SHALL have port Hrdata, output, 32 bits: read data, held until the next completion.
REQ-009 SHALL have port Htimeout, output, 1 bit: timeout flag, valid with Hready.
REQ-010 SHALL have port PSEL, output, 4 bits: one-hot APB slave select.
REQ-011 SHALL have port PENABLE, output, 1 bit: APB access phase.
REQ-012 SHALL have ports PADDR, output, 32 bits; PWRITE, output, 1 bit; PWDATA, output, 32 bits: APB address, direction, write data.
REQ-013 SHALL have ports PRDATA, input, 32 bits; PREADY, input, 1 bit: APB read data and slave ready.

Function
REQ-014 SHALL implement states IDLE, SETUP, ACCESS, DONE, HOLD.
REQ-015 IDLE: on Hen=1, SHALL register Haddr/Hwrite/Hwdata into PADDR/PWRITE/PWDATA; mapped address -> SETUP, unmapped -> DONE.
REQ-016 Decode: Haddr[31:14]=0 is mapped, PSEL bit Haddr[13:12] set; any other address is unmapped, SHALL NOT touch APB, and SHALL return Hrdata=0.
REQ-017 SETUP: PSEL one-hot, PENABLE=0, exactly one cycle, then ACCESS.
REQ-018 ACCESS: PSEL held, PENABLE=1; PADDR/PWRITE/PWDATA stable; stay until PREADY=1 sampled.
REQ-019 On PREADY=1 in ACCESS: read SHALL capture PRDATA into Hrdata; write SHALL leave Hrdata unchanged; PSEL=0, PENABLE=0; -> DONE.
REQ-020 DONE: Hready=1 for exactly one cycle, -> HOLD.
REQ-021 HOLD: Hready=0; stay while Hen=1; -> IDLE when Hen=0 (prevents re-issue of a held Hen).
REQ-022 Latency: Hen sampled at edge N, zero-wait slave -> Hready high after edge N+3; unmapped -> after edge N+1.
REQ-023 Hready SHALL be 0 in all states except DONE; Htimeout SHALL be 0 except in DONE after a timeout.
REQ-024 PREADY and PRDATA SHALL be ignored outside ACCESS.

Reset
REQ-025 Hrst=0 SHALL force IDLE immediately, any state including mid-ACCESS; abandoned transfer not completed.
REQ-026 Reset values: Hready=0, Htimeout=0, Hrdata=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, timeout counter=0.
REQ-027 After reset release, Hen=1 sampled in IDLE SHALL start a new transfer.

Configuration
REQ-028 Macro APB_TIMEOUT_EN defined: 4-bit counter, cleared on ACCESS entry, +1 per ACCESS cycle with PREADY=0; on 16th such cycle -> DONE, Hrdata=32'hFFFF_FFFF, Htimeout=1 during DONE, PSEL/PENABLE dropped.
REQ-029 Macro APB_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, Htimeout tied 0.

Verification
REQ-030 Read 0x0000_1004, PREADY=1 at once, PRDATA=0x1234_5678 -> PSEL=4'b0010, Hready pulse 3 cycles after Hen, Hrdata=0x1234_5678.
REQ-031 Write 0x0000_3010 data 0xA5A5_A5A5, PREADY low 2 ACCESS cycles -> PSEL=4'b1000, PWRITE=1, PWDATA stable, Hready 2 cycles later than zero-wait.
REQ-032 Read 0x0001_0000 -> no PSEL activity, Hready 1 cycle after Hen, Hrdata=0.
REQ-033 Hen held high 5 cycles after Hready -> exactly one APB transfer, single Hready pulse.
REQ-034 Hrst low during ACCESS -> PSEL=0, PENABLE=0, Hready=0 immediately; no Hready pulse.
REQ-035 APB_TIMEOUT_EN, PREADY stuck 0 -> Hready with Htimeout=1 and Hrdata=0xFFFF_FFFF after 16 ACCESS cycles; undefined: no Hready.
